// File: rtl/branch_predictor.sv
// branch_predictor: next-PC generation stage feeding the PC register.
// Direct-mapped BTB (valid/tag/target) plus a 2-bit saturating counter per
// entry. Prediction and mispredict resolution are combinational; tables are
// trained on the clock edge of each resolved branch/jump from EX.
// Optional build macro BP_STATS_EN adds branch and mispredict counters.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        EX_valid,
  input  logic        EX_is_jump,
  input  logic [31:0] EX_PC,
  input  logic        EX_taken,
  input  logic [31:0] EX_target,
  input  logic        EX_pred_taken,
  input  logic [31:0] EX_pred_target,
  output logic [31:0] next_PC,
  output logic        pred_taken,
  output logic [31:0] corrected_PC,
  output logic        Flush
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_LO  = IDX_BITS + 2;
  localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

  logic                btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [31:0]         btb_target [ENTRIES];
  logic [1:0]          bht        [ENTRIES];

  logic [IDX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0] fetch_tag;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                hit;
  logic [31:0]         pc_plus4;
  logic [31:0]         ex_plus4;
  logic [31:0]         actual_next;
  logic [31:0]         pred_next;
  logic                mispredict;

  // PC bits outside the index/tag fields never affect the tables
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC[31:TAG_HI+1], PC[1:0], EX_PC[31:TAG_HI+1], EX_PC[1:0]};

  assign fetch_idx = PC[IDX_BITS+1:2];
  assign fetch_tag = PC[TAG_HI:TAG_LO];
  assign ex_idx    = EX_PC[IDX_BITS+1:2];
  assign ex_tag    = EX_PC[TAG_HI:TAG_LO];

  // Fetch-side prediction: reads the current (pre-update) table contents
  always_comb begin
    pc_plus4   = PC + 32'd4;
    hit        = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
    pred_taken = hit && bht[fetch_idx][1];
    pred_next  = pred_taken ? btb_target[fetch_idx] : pc_plus4;
  end

  // EX-side resolution; Flush is held low while reset is asserted so a
  // recovery never escapes a reset in progress
  always_comb begin
    ex_plus4     = EX_PC + 32'd4;
    actual_next  = EX_taken ? EX_target : ex_plus4;
    mispredict   = (EX_pred_taken != EX_taken) ||
                   (EX_taken && (EX_pred_target != EX_target));
    Flush        = rst && EX_valid && mispredict;
    corrected_PC = actual_next;
    next_PC      = Flush ? corrected_PC : pred_next;
  end

  // Table training from the resolved branch; BHT is untagged and shared by
  // aliasing branches, BTB is only written by taken outcomes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        bht[i]        <= 2'b01;
      end
    end else if (EX_valid) begin
      if (EX_taken) begin
        btb_valid[ex_idx]  <= 1'b1;
        btb_tag[ex_idx]    <= ex_tag;
        btb_target[ex_idx] <= EX_target;
      end
      if (EX_is_jump) begin
        bht[ex_idx] <= 2'b11;
      end else if (EX_taken) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

`ifdef BP_STATS_EN
  // Free-running statistics, wrapping at 2**32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (EX_valid) stat_branches    <= stat_branches + 32'd1;
      if (Flush)    stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: each step drives one cycle of fetch
// and EX inputs, queues the expected outputs, then pops and checks them
// mid-cycle before the next rising edge.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic        EX_valid;
  logic        EX_is_jump;
  logic [31:0] EX_PC;
  logic        EX_taken;
  logic [31:0] EX_target;
  logic        EX_pred_taken;
  logic [31:0] EX_pred_target;
  logic [31:0] next_PC;
  logic        pred_taken;
  logic [31:0] corrected_PC;
  logic        Flush;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] nxt;
    logic        pt;
    logic        fl;
    logic [31:0] corr;
  } exp_t;

  exp_t sb[$];

  branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (PC),
    .EX_valid       (EX_valid),
    .EX_is_jump     (EX_is_jump),
    .EX_PC          (EX_PC),
    .EX_taken       (EX_taken),
    .EX_target      (EX_target),
    .EX_pred_taken  (EX_pred_taken),
    .EX_pred_target (EX_pred_target),
    .next_PC        (next_PC),
    .pred_taken     (pred_taken),
    .corrected_PC   (corrected_PC),
    .Flush          (Flush)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic push(input string name, input logic [31:0] nxt, input logic pt,
                      input logic fl, input logic [31:0] corr);
    exp_t e;
    e.name = name; e.nxt = nxt; e.pt = pt; e.fl = fl; e.corr = corr;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".next_PC"},      next_PC,      e.nxt);
    chk({e.name, ".pred_taken"},   {31'd0, pred_taken}, {31'd0, e.pt});
    chk({e.name, ".Flush"},        {31'd0, Flush},      {31'd0, e.fl});
    chk({e.name, ".corrected_PC"}, corrected_PC, e.corr);
  endtask

  task automatic drive(input logic [31:0] pc, input logic exv, input logic jump,
                       input logic [31:0] expc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    PC = pc; EX_valid = exv; EX_is_jump = jump; EX_PC = expc;
    EX_taken = tk; EX_target = tgt; EX_pred_taken = ptk; EX_pred_target = ptgt;
  endtask

  // One cycle: drive just after the edge, check mid-cycle, advance
  task automatic step(input string name, input logic [31:0] pc, input logic exv,
                      input logic jump, input logic [31:0] expc, input logic tk,
                      input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                      input logic [31:0] e_nxt, input logic e_pt, input logic e_fl,
                      input logic [31:0] e_corr);
    drive(pc, exv, jump, expc, tk, tgt, ptk, ptgt);
    push(name, e_nxt, e_pt, e_fl, e_corr);
    #4;
    pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name, input logic [31:0] pc,
                      input logic [31:0] e_nxt, input logic e_pt);
    step(name, pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, e_nxt, e_pt, 1'b0, 32'h4);
  endtask

  initial begin
    rst = 1'b0;
    drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    push("reset", 32'h44, 1'b0, 1'b0, 32'h4);
    pop_check();
    @(posedge clk);
    #1;
    rst = 1'b1;

    step("cold",    32'h40, 1, 0, 32'h40, 1, 32'h100, 0, 32'h44,  32'h100, 0, 1, 32'h100);
    idle("warm",    32'h40, 32'h100, 1'b1);
    step("sat1",    32'h40, 1, 0, 32'h40, 1, 32'h100, 1, 32'h100, 32'h100, 1, 0, 32'h100);
    step("sat2",    32'h40, 1, 0, 32'h40, 1, 32'h100, 1, 32'h100, 32'h100, 1, 0, 32'h100);
    step("sat3",    32'h40, 1, 0, 32'h40, 1, 32'h100, 1, 32'h100, 32'h100, 1, 0, 32'h100);
    step("nt1",     32'h40, 1, 0, 32'h40, 0, 32'h100, 1, 32'h100, 32'h44,  1, 1, 32'h44);
    step("nt2",     32'h40, 1, 0, 32'h40, 0, 32'h100, 1, 32'h100, 32'h44,  1, 1, 32'h44);
    idle("weak_nt", 32'h40, 32'h44, 1'b0);
    step("wrongtg", 32'h40, 1, 0, 32'h40, 1, 32'h200, 1, 32'h100, 32'h200, 0, 1, 32'h200);
    idle("newtg",   32'h40, 32'h200, 1'b1);
    step("rbw",     32'h40, 1, 0, 32'h40, 1, 32'h300, 1, 32'h300, 32'h200, 1, 0, 32'h300);
    idle("rbw_after", 32'h40, 32'h300, 1'b1);
    idle("alias_miss", 32'h140, 32'h144, 1'b0);
    step("alias_wr", 32'h140, 1, 0, 32'h140, 1, 32'h500, 0, 32'h144, 32'h500, 0, 1, 32'h500);
    idle("alias_old", 32'h40, 32'h44, 1'b0);
    idle("alias_new", 32'h140, 32'h500, 1'b1);
    idle("pc_wrap", 32'hFFFF_FFFC, 32'h0, 1'b0);
    step("no_upd",  32'h140, 0, 0, 32'h140, 1, 32'h700, 0, 32'h144, 32'h500, 1, 0, 32'h700);
    idle("no_upd_after", 32'h140, 32'h500, 1'b1);
    step("jump",    32'h80, 1, 1, 32'h80, 1, 32'h900, 0, 32'h84,  32'h900, 0, 1, 32'h900);
    step("jump_nt", 32'h80, 1, 0, 32'h80, 0, 32'h900, 1, 32'h900, 32'h84,  1, 1, 32'h84);
    idle("jump_hold", 32'h80, 32'h900, 1'b1);
    step("ex_wrap", 32'h80, 1, 0, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, 32'h0, 1, 1, 32'h0);

    // Reset asserted mid-cycle while a mispredict is being resolved
    drive(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h400, 1'b0, 32'h44);
    push("pre_rst", 32'h400, 1'b0, 1'b1, 32'h400);
    #2;
    pop_check();
    rst = 1'b0;
    push("in_rst", 32'h44, 1'b0, 1'b0, 32'h400);
    #1;
    pop_check();
    PC = 32'h140;
    push("rst_clear", 32'h144, 1'b0, 1'b0, 32'h400);
    #1;
    pop_check();
    EX_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle("post_rst", 32'h80, 32'h84, 1'b0);

    // Five resolved branches, two of them mispredicted
    step("s1", 32'h0, 1, 0, 32'h40, 1, 32'h100, 0, 32'h44,  32'h100, 0, 1, 32'h100);
    step("s2", 32'h0, 1, 0, 32'h40, 1, 32'h100, 1, 32'h100, 32'h4,   0, 0, 32'h100);
    step("s3", 32'h0, 1, 0, 32'h40, 0, 32'h100, 0, 32'h44,  32'h4,   0, 0, 32'h44);
    step("s4", 32'h0, 1, 0, 32'h40, 0, 32'h100, 1, 32'h100, 32'h44,  0, 1, 32'h44);
    step("s5", 32'h0, 1, 1, 32'h80, 1, 32'h900, 1, 32'h900, 32'h4,   0, 0, 32'h900);
    idle("s_idle", 32'h0, 32'h4, 1'b0);
`ifdef BP_STATS_EN
    chk("stat_branches",    stat_branches,    32'd5);
    chk("stat_mispredicts", stat_mispredicts, 32'd2);
    rst = 1'b0;
    #1;
    chk("stat_branches_rst",    stat_branches,    32'd0);
    chk("stat_mispredicts_rst", stat_mispredicts, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Next-PC generation stage that sits directly upstream of the PC register.
- Each cycle it takes the current fetch PC and produces next_PC, using a direct-mapped branch target buffer (BTB) and 2-bit saturating branch history counters (BHT).
- Execute-stage branch resolution trains the tables, detects mispredictions, and drives Flush and corrected_PC.
- On a mispredict, next_PC is forced to corrected_PC so the PC register loads the recovery address on the next edge.

Parameters:
- IDX_BITS, 6, index width; tables hold 2**IDX_BITS entries, indexed by PC[IDX_BITS+1:2].
- TAG_BITS, 8, partial tag width, taken from PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- PC  in  32  current fetch PC.
- EX_valid  in  1  resolved branch/jump present in EX this cycle; asserted for exactly one cycle per instruction.
- EX_is_jump  in  1  resolved instruction is JAL/JALR (unconditional).
- EX_PC  in  32  PC of the resolved instruction.
- EX_taken  in  1  actual direction.
- EX_target  in  32  actual target.
- EX_pred_taken  in  1  prediction made at fetch, carried down the pipe.
- EX_pred_target  in  32  predicted next PC, carried down the pipe.
- next_PC  out  32  PC for the next fetch.
- pred_taken  out  1  prediction for the current PC; pipelined downstream.
- corrected_PC  out  32  recovery address.
- Flush  out  1  mispredict detected; flush IF/ID and ID/EX.

Behaviour:
- Reset (rst=0, asynchronous):
  - all BTB valid bits clear;
  - all BHT counters set to 2'b01 (weakly not-taken);
  - statistics counters (if compiled in) cleared.
  - Outputs are combinational. During reset, with EX_valid=0: next_PC=PC+4, pred_taken=0, Flush=0, corrected_PC=EX_PC+4.
- Prediction (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==PC tag field.
  - pred_taken = hit && BHT[idx][1].
  - Prediction value = pred_taken ? BTB_target[idx] : PC+4.
- Resolution (combinational within the EX_valid cycle):
  - actual_next = EX_taken ? EX_target : EX_PC+4.
  - Flush = EX_valid && (EX_pred_taken!=EX_taken || (EX_taken && EX_pred_target!=EX_target)).
  - corrected_PC = actual_next.
  - next_PC = Flush ? corrected_PC : prediction value. Flush has priority over the fetch prediction.
- Update (on the clock edge when EX_valid=1), using EX_PC index and tag:
  - if EX_taken: write the BTB entry (valid=1, tag, target=EX_target);
  - if !EX_taken: BTB unchanged, including on a tag mismatch;
  - BHT counter: jump sets it to 2'b11; conditional branch increments on taken, decrements on not-taken, saturating at 2'b11 and 2'b00.
  - No update when EX_valid=0, regardless of EX_* values.
- Simultaneous fetch read and EX write to the same index: the fetch sees the old entry (read-before-write); the new value is visible from the next cycle.
- Aliasing: a tag mismatch is a miss; a colliding taken branch overwrites the entry.
- Stall is not an input. Stall never gates updates, and the hazard unit must not assert Stall in a Flush cycle. Assertion: Flush && Stall is an error.
- Reset mid-operation: tables clear asynchronously and Flush drops to 0 immediately (given EX_valid=0).
- Arithmetic: PC+4 and EX_PC+4 wrap modulo 2**32 (0xFFFFFFFC+4 = 0x00000000).

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - adds outputs stat_branches[31:0] and stat_mispredicts[31:0];
  - stat_branches increments on every EX_valid edge;
  - stat_mispredicts increments on every edge with Flush=1;
  - both wrap at 2**32 and both clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then PC=0x00000040 with EX_valid=0 -> next_PC=0x00000044, pred_taken=0, Flush=0.
- Cold branch: EX_valid=1, EX_PC=0x40, EX_taken=1, EX_target=0x100, EX_pred_taken=0 -> Flush=1, corrected_PC=next_PC=0x100. Next cycle, PC=0x40 -> pred_taken=1 (counter 01->10), next_PC=0x100.
- Saturation: three more taken updates at 0x40 keep the counter at 11. Then two not-taken updates -> counter 01, and PC=0x40 predicts 0x44.
- Wrong target: EX_pred_taken=1, EX_pred_target=0x100, EX_taken=1, EX_target=0x200 -> Flush=1, corrected_PC=0x200, BTB target becomes 0x200.
- Same-cycle read/write at index of 0x40 with PC=0x40 -> prediction uses the pre-update entry; the following cycle uses the new one. Also PC=0xFFFFFFFC miss -> next_PC=0x00000000.
- Assert rst low while Flush=1 -> Flush=0 with no clock edge. With BP_STATS_EN defined: 5 branches, 2 mispredicts -> stat_branches=5, stat_mispredicts=2; reset clears both.
